bf_history_unit: RTL

BF_HISTORY_UNIT -- requirements
Module: bf_history_unit

---
 rtl/bf_pkg.sv | 32 +++
 rtl/bf_history_bank.sv | 20 ++
 rtl/bf_history_unit.sv | 44 ++++
 3 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared widths, types and the single-bank update rule for the filtered branch history.
package bf_pkg;
   localparam int HIST_LEN = 48;
   localparam int PC_W     = 16;
   localparam int POS_W    = 6;
   localparam int POS_MAX  = 63;
   localparam int CNT_W    = $clog2(HIST_LEN + 1);
   typedef logic [HIST_LEN:1][PC_W:1]  Branch;
   typedef logic [HIST_LEN:1][POS_W:1] Pos;
   typedef enum logic {RUN, RESTORE} state_t;
   typedef struct packed {
      logic [HIST_LEN:1] hist;
      Branch             addr;
      Pos                pos;
      logic [CNT_W-1:0]  cnt;
   } bank_t;
   // Every event ages all positions; only non-biased events shift in a new newest entry.
   function automatic bank_t bank_next(input bank_t q, input logic ins, input logic [PC_W:1] pc,
                                       input logic taken, input logic biased);
      bank_t n;
      n = q;
      for (int i = 1; i <= HIST_LEN; i++)
         n.pos[i] = (q.pos[i] == POS_W'(POS_MAX)) ? q.pos[i] : q.pos[i] + 1'b1;
      if (!biased) begin
         n.hist = {taken, n.hist[HIST_LEN:2]};
         n.addr = {pc, n.addr[HIST_LEN:2]};
         n.pos  = {POS_W'(1), n.pos[HIST_LEN:2]};
         n.cnt  = (q.cnt == CNT_W'(HIST_LEN)) ? q.cnt : q.cnt + 1'b1;
      end
      return ins ? n : q;
   endfunction
endpackage

// File: rtl/bf_history_bank.sv
// bf_history_bank: one filtered-history bank with its insertion counter; a load overrides any insert.
module bf_history_bank
   import bf_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ins_valid,
   input  logic [PC_W:1]   pc,
   input  logic            taken,
   input  logic            biased,
   input  logic            load_valid,
   input  bank_t           load_data,
   output bank_t           q
);
   bank_t r_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_q <= '0;
      else        r_q <= load_valid ? load_data : bank_next(r_q, ins_valid, pc, taken, biased);
   assign q = r_q;
endmodule

// File: rtl/bf_history_unit.sv
// bf_history_unit: speculative and architectural filtered histories with one-cycle restore on mispredict.
module bf_history_unit
   import bf_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                spec_valid,
   input  logic [PC_W:1]       spec_pc,
   input  logic                spec_taken,
   input  logic                spec_biased,
   output logic                spec_ready,
   input  logic                commit_valid,
   input  logic [PC_W:1]       commit_pc,
   input  logic                commit_taken,
   input  logic                commit_biased,
   input  logic                mispredict,
   output logic [HIST_LEN:1]   Folded_hist_iterative,
   output Branch               Branch_address_iterative,
   output Pos                  Pos_iterative,
   output logic                hist_full
);
   state_t r_state;
   bank_t  w_spec, w_arch, w_arch_next;
   logic   w_mp;
   assign w_mp       = commit_valid && mispredict;
   assign spec_ready = (r_state == RUN) && !w_mp;
   // Restore takes ARCH's next value so a commit landing in the restore cycle is not lost.
   assign w_arch_next = bank_next(w_arch, commit_valid, commit_pc, commit_taken, commit_biased);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= RUN;
      else        r_state <= (r_state == RUN && w_mp) ? RESTORE : RUN;
   bf_history_bank u_arch (
      .clk(clk), .rst_n(rst_n), .ins_valid(commit_valid), .pc(commit_pc), .taken(commit_taken),
      .biased(commit_biased), .load_valid(1'b0), .load_data('0), .q(w_arch)
   );
   bf_history_bank u_spec (
      .clk(clk), .rst_n(rst_n), .ins_valid(spec_valid && spec_ready), .pc(spec_pc), .taken(spec_taken),
      .biased(spec_biased), .load_valid(r_state == RESTORE), .load_data(w_arch_next), .q(w_spec)
   );
   assign Folded_hist_iterative    = w_spec.hist;
   assign Branch_address_iterative = w_spec.addr;
   assign Pos_iterative            = w_spec.pos;
   assign hist_full                = (w_spec.cnt == CNT_W'(HIST_LEN));
endmodule
